// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding RV32I load/store, classified at acceptance and
// issued to a one-cycle-latency memory port; response held until handshaken.
module load_store_unit #(
   parameter int unsigned MEM_WIDTH = 15,
   parameter int unsigned MLEN      = 64
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [2:0]           req_funct3,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [31:0]          resp_rdata,
   output logic [1:0]           resp_exc,
   output logic [2:0]           mem_funct3,
   output logic [MEM_WIDTH-1:0] mem_rd_addr,
   input  logic [MLEN-1:0]      mem_rd_data,
   output logic [MEM_WIDTH-1:0] mem_wr_addr,
   output logic [MLEN-1:0]      mem_wr_data,
   output logic                 mem_wr_en,
   input  logic [1:0]           mem_error
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   localparam logic [1:0] ExcOk       = 2'b00;
   localparam logic [1:0] ExcMisalign = 2'b01;
   localparam logic [1:0] ExcFault    = 2'b10;
   localparam logic [1:0] ExcIllegal  = 2'b11;

   state_e                 state_q, state_d;
   logic                   we_q;
   logic [2:0]             funct3_q;
   logic [MEM_WIDTH-1:0]   addr_q;
   logic [31:0]            wdata_q;
   logic [1:0]             exc_q;
   logic [31:0]            rdata_q;

   logic                   accept;
   logic                   illegal, misaligned, out_of_range;
   logic [1:0]             req_exc;
   logic                   mem_err_hit;
   logic                   unused_rd_upper;

   assign req_ready = (state_q == StIdle) && !areset;
   assign accept    = req_valid && req_ready;

   // Classification of the incoming request; priority illegal > misaligned > range.
   always_comb begin
      illegal      = 1'b0;
      misaligned   = 1'b0;
      out_of_range = |req_addr[31:MEM_WIDTH];
      if (req_we) begin
         illegal = (req_funct3 > 3'b010);
      end else begin
         illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
      end
      unique case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         default: misaligned = 1'b0;
      endcase
      if (illegal) begin
         req_exc = ExcIllegal;
      end else if (misaligned) begin
         req_exc = ExcMisalign;
      end else if (out_of_range) begin
         req_exc = ExcFault;
      end else begin
         req_exc = ExcOk;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = (req_exc != ExcOk) ? StResp : StIssue;
         StIssue: state_d = StWait;
         StWait:  state_d = StResp;
         StResp:  if (resp_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   assign mem_err_hit = we_q ? mem_error[1] : mem_error[0];

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q  <= StIdle;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         exc_q    <= ExcOk;
         rdata_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr[MEM_WIDTH-1:0];
            wdata_q  <= req_wdata;
            exc_q    <= req_exc;
            rdata_q  <= 32'h0;
         end else if (state_q == StWait) begin
            if (mem_err_hit) begin
               exc_q   <= ExcFault;
               rdata_q <= 32'h0;
            end else begin
               rdata_q <= we_q ? 32'h0 : mem_rd_data[31:0];
            end
         end
      end
   end

   assign mem_funct3  = funct3_q;
   assign mem_rd_addr = addr_q;
   assign mem_wr_addr = addr_q;
   assign mem_wr_data = MLEN'(wdata_q);
   assign mem_wr_en   = (state_q == StIssue) && we_q;

   // Response fields read as zero outside RESP so idle values never leak.
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = resp_valid ? rdata_q : 32'h0;
   assign resp_exc   = resp_valid ? exc_q : ExcOk;

   assign unused_rd_upper = ^mem_rd_data[MLEN-1:32];

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model behind the
// memory port (one-cycle read latency, size/sign handled by the memory).
module tb_load_store_unit;

   localparam int unsigned MW = 15;
   localparam int unsigned ML = 64;

   logic          clk;
   logic          areset;
   logic          req_valid, req_ready, req_we;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr, req_wdata;
   logic          resp_valid, resp_ready;
   logic [31:0]   resp_rdata;
   logic [1:0]    resp_exc;
   logic [2:0]    mem_funct3;
   logic [MW-1:0] mem_rd_addr, mem_wr_addr;
   logic [ML-1:0] mem_rd_data, mem_wr_data;
   logic          mem_wr_en;
   logic [1:0]    mem_error;
   logic [1:0]    inj_err;

   int n_vec = 0;
   int n_err = 0;
   int wr_cnt = 0;

   logic [7:0]    mem [0:(1<<MW)-1];
   logic [ML-1:0] rd_q;

   load_store_unit #(.MEM_WIDTH(MW), .MLEN(ML)) dut (
      .clk         (clk),
      .areset      (areset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_rdata  (resp_rdata),
      .resp_exc    (resp_exc),
      .mem_funct3  (mem_funct3),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_en   (mem_wr_en),
      .mem_error   (mem_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rd_data = rd_q;
   assign mem_error   = inj_err;

   function automatic logic [ML-1:0] mem_read(input logic [MW-1:0] a, input logic [2:0] f);
      logic [31:0] w;
      w = {mem[a + MW'(3)], mem[a + MW'(2)], mem[a + MW'(1)], mem[a]};
      case (f)
         3'b000:  return ML'({{24{w[7]}}, w[7:0]});
         3'b100:  return ML'({24'h0, w[7:0]});
         3'b001:  return ML'({{16{w[15]}}, w[15:0]});
         3'b101:  return ML'({16'h0, w[15:0]});
         default: return ML'(w);
      endcase
   endfunction

   always @(posedge clk) begin
      rd_q <= mem_read(mem_rd_addr, mem_funct3);
      if (mem_wr_en) begin
         wr_cnt <= wr_cnt + 1;
         mem[mem_wr_addr] <= mem_wr_data[7:0];
         if (mem_funct3[1:0] != 2'b00) mem[mem_wr_addr + MW'(1)] <= mem_wr_data[15:8];
         if (mem_funct3[1:0] == 2'b10) begin
            mem[mem_wr_addr + MW'(2)] <= mem_wr_data[23:16];
            mem[mem_wr_addr + MW'(3)] <= mem_wr_data[31:24];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // lat counts cycles from the accepting cycle to the first cycle with resp_valid.
   task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] eexc, input logic [31:0] erd,
                         input int elat, input int hold);
      int w0, n;
      check({tag, ".ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      w0 = wr_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check({tag, ".busy"}, 32'(req_ready), 32'd0);
      n = 1;
      while (!resp_valid && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ".lat"}, 32'(n), 32'(elat));
      check({tag, ".exc"}, 32'(resp_exc), 32'(eexc));
      check({tag, ".rdata"}, resp_rdata, erd);
      check({tag, ".wr"}, 32'(wr_cnt - w0), (we && elat == 3) ? 32'd1 : 32'd0);
      check({tag, ".addr"}, 32'(mem_rd_addr), 32'(addr[MW-1:0]));
      check({tag, ".f3"}, 32'(mem_funct3), 32'(f3));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, ".hold_v"}, 32'(resp_valid), 32'd1);
         check({tag, ".hold_d"}, resp_rdata, erd);
         check({tag, ".hold_e"}, 32'(resp_exc), 32'(eexc));
         check({tag, ".hold_r"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check({tag, ".done"}, {30'h0, resp_valid, |resp_exc}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w0;
      areset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0; inj_err = 2'b00;
      repeat (2) @(posedge clk);
      #1;
      check("rst.ready", 32'(req_ready), 32'd0);
      check("rst.valid", 32'(resp_valid), 32'd0);
      check("rst.wr_en", 32'(mem_wr_en), 32'd0);
      check("rst.rdata", resp_rdata, 32'h0);
      check("rst.outs", 32'(mem_wr_addr) | 32'(mem_rd_addr) | 32'(mem_funct3)
                        | 32'(resp_exc) | mem_wr_data[31:0], 32'h0);
      areset = 1'b0;
      #1;
      check("rst.release", 32'(req_ready), 32'd1);

      do_req("sw100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2'b00, 32'h0, 3, 0);
      check("sw100.wdata_hi", mem_wr_data[63:32], 32'h0);
      check("sw100.wdata_lo", mem_wr_data[31:0], 32'hDEADBEEF);
      do_req("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 2'b00, 32'hDEADBEEF, 3, 0);
      do_req("sb103", 1'b1, 3'b000, 32'h103, 32'h12345680, 2'b00, 32'h0, 3, 0);
      do_req("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 2'b00, 32'hFFFFFF80, 3, 0);
      do_req("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 2'b00, 32'h00000080, 3, 0);
      do_req("lw100b", 1'b0, 3'b010, 32'h100, 32'h0, 2'b00, 32'h80ADBEEF, 3, 0);
      do_req("sh106", 1'b1, 3'b001, 32'h106, 32'h0000BEEF, 2'b00, 32'h0, 3, 0);
      do_req("lh106", 1'b0, 3'b001, 32'h106, 32'h0, 2'b00, 32'hFFFFBEEF, 3, 0);
      do_req("lhu106", 1'b0, 3'b101, 32'h106, 32'h0, 2'b00, 32'h0000BEEF, 3, 0);

      do_req("lh101", 1'b0, 3'b001, 32'h101, 32'h0, 2'b01, 32'h0, 1, 0);
      do_req("sw102", 1'b1, 3'b010, 32'h102, 32'h11111111, 2'b01, 32'h0, 1, 0);
      do_req("lw8000", 1'b0, 3'b010, 32'h8000, 32'h0, 2'b10, 32'h0, 1, 0);
      do_req("lb_top", 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 2'b10, 32'h0, 1, 0);
      do_req("ld011", 1'b0, 3'b011, 32'h100, 32'h0, 2'b11, 32'h0, 1, 0);
      do_req("sd100", 1'b1, 3'b100, 32'h100, 32'h0, 2'b11, 32'h0, 1, 0);
      do_req("ill_pri", 1'b0, 3'b011, 32'h8001, 32'h0, 2'b11, 32'h0, 1, 0);
      do_req("mis_pri", 1'b0, 3'b010, 32'h8002, 32'h0, 2'b01, 32'h0, 1, 0);
      do_req("lw_after", 1'b0, 3'b010, 32'h100, 32'h0, 2'b00, 32'h80ADBEEF, 3, 0);

      inj_err = 2'b01;
      do_req("rd_err", 1'b0, 3'b010, 32'h100, 32'h0, 2'b10, 32'h0, 3, 0);
      inj_err = 2'b10;
      do_req("rd_wrerr", 1'b0, 3'b010, 32'h100, 32'h0, 2'b00, 32'h80ADBEEF, 3, 0);
      do_req("wr_err", 1'b1, 3'b010, 32'h108, 32'h01020304, 2'b10, 32'h0, 3, 0);
      inj_err = 2'b00;

      do_req("hold", 1'b0, 3'b010, 32'h100, 32'h0, 2'b00, 32'h80ADBEEF, 3, 3);
      do_req("b2b", 1'b0, 3'b010, 32'h108, 32'h0, 2'b00, 32'h01020304, 3, 0);

      do_req("sw200", 1'b1, 3'b010, 32'h200, 32'hCAFEF00D, 2'b00, 32'h0, 3, 0);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h200; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("abort.issue_wr", 32'(mem_wr_en), 32'd1);
      w0 = wr_cnt;
      areset = 1'b1;
      #1;
      check("abort.wr_drop", 32'(mem_wr_en), 32'd0);
      check("abort.ready", 32'(req_ready), 32'd0);
      check("abort.addr", 32'(mem_wr_addr), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      areset = 1'b0;
      #1;
      check("abort.release", 32'(req_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("abort.no_resp", 32'(resp_valid), 32'd0);
      end
      check("abort.no_write", 32'(wr_cnt - w0), 32'd0);
      do_req("lw200", 1'b0, 3'b010, 32'h200, 32'h0, 2'b00, 32'hCAFEF00D, 3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
